// File: rtl/gaussian_sdiv_34_18.sv
// rtl/gaussian_sdiv_34_18.sv - constant-time signed restoring divider, 34-bit / 18-bit -> 16-bit q, 18-bit r
// Define GAUSSIAN_SDIV_SAT_EN to saturate the quotient on overflow (default build wraps).
module gaussian_sdiv_34_18 #(
  parameter int DW = 34,
  parameter int VW = 18,
  parameter int QW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          overflow
);

  localparam int            CW        = $clog2(DW);
  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);
  localparam logic [DW-1:0] POS_LIM   = DW'((1 << (QW - 1)) - 1);
  localparam logic [DW-1:0] NEG_LIM   = DW'(1 << (QW - 1));
  localparam logic [QW-1:0] Q_MAX     = {1'b0, {(QW - 1){1'b1}}};
  localparam logic [QW-1:0] Q_MIN     = {1'b1, {(QW - 1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dvd_q, dvd_d;    // dividend magnitude, shifted out as quotient bits shift in
  logic [VW-1:0] prem_q, prem_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic          sd_q, sd_d;
  logic          sv_q, sv_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;
  logic          vld_q, vld_d;

  logic [VW:0]   trial;
  logic [VW:0]   trial_sub;
  logic          take;
  logic          neg_q;
  logic          q_ovf;
  logic [QW-1:0] q_wrap;
  logic [VW-1:0] r_signed;

  // The VW+1-bit partial remainder; after the restore step it always fits in VW bits.
  assign trial     = {prem_q, dvd_q[DW-1]};
  assign trial_sub = trial - {1'b0, dvs_q};
  assign take      = (trial >= {1'b0, dvs_q});

  assign neg_q    = sd_q ^ sv_q;
  assign q_ovf    = neg_q ? (dvd_q > NEG_LIM) : (dvd_q > POS_LIM);
  assign q_wrap   = neg_q ? (~dvd_q[QW-1:0] + QW'(1)) : dvd_q[QW-1:0];
  assign r_signed = sd_q ? (~prem_q + VW'(1)) : prem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    prem_d  = prem_q;
    dvs_d   = dvs_q;
    sd_d    = sd_q;
    sv_d    = sv_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sd_d    = dividend[DW-1];
          sv_d    = divisor[VW-1];
          dvd_d   = dividend[DW-1] ? (~dividend + DW'(1)) : dividend;
          dvs_d   = divisor[VW-1] ? (~divisor + VW'(1)) : divisor;
          prem_d  = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        prem_d = take ? trial_sub[VW-1:0] : trial[VW-1:0];
        dvd_d  = {dvd_q[DW-2:0], take};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        dz_d = (dvs_q == '0);
        if (dvs_q == '0) begin
          quo_d = sd_q ? Q_MIN : Q_MAX;
          rem_d = '0;
          ovf_d = 1'b0;
        end else begin
          ovf_d = q_ovf;
          rem_d = r_signed;
`ifdef GAUSSIAN_SDIV_SAT_EN
          quo_d = q_ovf ? (neg_q ? Q_MIN : Q_MAX) : q_wrap;
`else
          quo_d = q_wrap;
`endif
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (out_ready) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      prem_q  <= '0;
      dvs_q   <= '0;
      sd_q    <= 1'b0;
      sv_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      prem_q  <= prem_d;
      dvs_q   <= dvs_d;
      sd_q    <= sd_d;
      sv_q    <= sv_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = vld_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_gaussian_sdiv_34_18.sv
// tb/tb_gaussian_sdiv_34_18.sv - scoreboard bench for gaussian_sdiv_34_18
module tb_gaussian_sdiv_34_18;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] dividend;
  logic [17:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [17:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  gaussian_sdiv_34_18 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] q;
    logic [17:0] r;
    logic        dz;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // C semantics: truncate toward zero, remainder carries the dividend's sign.
  function automatic exp_t model(input longint a, input longint b);
    exp_t   e;
    longint qt;
    longint rt;
    if (b == 0) begin
      e.q   = (a >= 0) ? 16'h7FFF : 16'h8000;
      e.r   = '0;
      e.dz  = 1'b1;
      e.ovf = 1'b0;
    end else begin
      qt    = a / b;
      rt    = a % b;
      e.dz  = 1'b0;
      e.ovf = (qt > 32767) || (qt < -32768);
      e.q   = qt[15:0];
      e.r   = rt[17:0];
`ifdef GAUSSIAN_SDIV_SAT_EN
      if (e.ovf) e.q = (qt > 0) ? 16'h7FFF : 16'h8000;
`endif
    end
    return e;
  endfunction

  task automatic run_op(input longint a, input longint b, input int hold);
    exp_t   e;
    int     waited;
    longint acc;
    sb_q.push_back(model(a, b));
    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_eq("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    dividend = a[33:0];
    divisor  = b[17:0];
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("in_ready_busy", in_ready, 0);
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    e = sb_q.pop_front();
    if (!out_valid) begin
      check_eq("valid_timeout", out_valid, 1);
      return;
    end
    check_eq("latency", cyc - acc, 36);
    check_eq("quotient", quotient, e.q);
    check_eq("remainder", remainder, e.r);
    check_eq("div_by_zero", div_by_zero, e.dz);
    check_eq("overflow", overflow, e.ovf);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i % 2 == 0);
      dividend = 34'h1234;
      divisor  = 18'h5;
      @(negedge clk);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_in_ready", in_ready, 0);
      check_eq("hold_quotient", quotient, e.q);
      check_eq("hold_remainder", remainder, e.r);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("valid_drop", out_valid, 0);
    check_eq("in_ready_back", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int     stale;
    longint ra;
    longint rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_quotient", quotient, 0);
    check_eq("rst_remainder", remainder, 0);
    check_eq("rst_dz", div_by_zero, 0);
    check_eq("rst_ovf", overflow, 0);
    rst = 1'b0;

    run_op(100, 7, 0);
    run_op(-100, 7, 0);
    run_op(100, -7, 0);
    run_op(-7006652, 5678, 0);
    run_op(5, 0, 0);
    run_op(-5, 0, 0);
    run_op(65536, 1, 0);
    run_op(-(64'sd1 <<< 33), -1, 0);
    run_op(1000, -3, 10);

    // abort mid-CALC, with in_valid held high across the reset edge
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 34'd999999;
    divisor  = 18'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("mid_busy", in_ready, 0);
    rst      = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_quotient", quotient, 0);
    check_eq("abort_remainder", remainder, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    stale = 0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check_eq("no_stale", stale, 0);
    check_eq("idle_after_abort", in_ready, 1);

    run_op((64'sd1 <<< 33) - 1, -131072, 0);
    run_op(-(64'sd1 <<< 33), -131072, 0);
    run_op(-98304, 3, 0);
    run_op(32768, -1, 0);
    run_op(32768, 1, 0);
    run_op(0, 5, 0);
    run_op(-1, 131071, 0);

    for (int k = 0; k < 10; k++) begin
      ra = longint'($urandom_range(0, 4000000)) - 2000000;
      rb = longint'($urandom_range(0, 4000)) - 2000;
      run_op(ra, rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
